// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M issue/retire controller: FSM state
// encoding, funct3 constants and the funct3 -> muldiv-unit control mapping.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } md_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Control word as seen by the multiplier/divider unit.
  typedef struct packed {
    logic [1:0] op_mul;  // funct3[1:0]
    logic [1:0] op_div;  // [1]=remainder, [0]=signed
    logic       sel;     // 1 = divide path
  } md_ctrl_t;

  function automatic md_ctrl_t md_decode(input logic [2:0] funct3);
    md_ctrl_t c;
    c.op_mul = funct3[1:0];
    c.op_div = {funct3[1], ~funct3[0]};
    c.sel    = funct3[2];
    return c;
  endfunction

  // Inverse of md_decode; used to tag cached results with their funct3.
  function automatic logic [2:0] md_f3(input md_ctrl_t c);
    return {c.sel, c.op_mul};
  endfunction

endpackage

// File: rtl/muldiv_issue_fsm.sv
// Issue/retire state machine: IDLE -> RUN -> HOLD -> IDLE, with DRAIN to
// swallow the completion of an op that was flushed while in flight.
// md_start and wb_valid are registered; stall is combinational because it
// must drop in the very cycle writeback accepts the result.
module muldiv_issue_fsm
  import muldiv_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,       // asynchronous, active-low
  input  logic ex_valid_i,
  input  logic ex_is_muldiv_i,
  input  logic flush_i,
  input  logic md_done_i,
  input  logic wb_ready_i,
  input  logic cache_hit_i,
  output logic stall_o,
  output logic md_start_o,
  output logic wb_valid_o,
  output logic accept_o,      // latch the EX operands this cycle
  output logic capture_o      // latch md_R into the result register
);

  md_state_e state_q;
  logic      md_start_q;
  logic      wb_valid_q;
  logic      ex_md;

  assign ex_md     = ex_valid_i & ex_is_muldiv_i;
  assign accept_o  = (state_q == ST_IDLE) & ex_md & ~flush_i;
  assign capture_o = (state_q == ST_RUN) & md_done_i & ~flush_i;

  // Freeze the front end while a muldiv sits in EX, except in the retire cycle.
  assign stall_o = reset_i & ex_md & ~((state_q == ST_HOLD) & wb_ready_i);

  assign md_start_o = md_start_q;
  assign wb_valid_o = wb_valid_q;

  // State register with registered launch pulse and result-valid flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      md_start_q <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_o) begin
            if (cache_hit_i) begin
              state_q    <= ST_HOLD;
              wb_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              md_start_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            // A completion arriving with the flush is simply dropped.
            state_q <= md_done_i ? ST_IDLE : ST_DRAIN;
          end else if (md_done_i) begin
            state_q    <= ST_HOLD;
            wb_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush_i || wb_ready_i) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (md_done_i) state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/muldiv_issue.sv
// Execute-stage issue/retire controller for RV32M ops. Holds operands and
// control stable for the muldiv unit, captures its result and hands it to
// writeback over valid/ready.
// Optional feature: define MULDIV_RESULT_CACHE_EN to keep the last retired
// {funct3, rs1, rs2, result}; a matching op then skips the unit entirely.
module muldiv_issue
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_is_muldiv,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [RW-1:0]   ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            md_start,
  output logic [XLEN-1:0] md_A,
  output logic [XLEN-1:0] md_B,
  output logic [1:0]      md_op_mul,
  output logic [1:0]      md_op_div,
  output logic            md_sel,
  input  logic [XLEN-1:0] md_R,
  input  logic            md_done,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data
);

  logic            accept;
  logic            capture;
  logic            cache_hit;
  logic [XLEN-1:0] hit_data;

  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  md_ctrl_t        ctrl_q, ctrl_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  muldiv_issue_fsm u_fsm (
    .clk_i          (clk),
    .reset_i        (reset),
    .ex_valid_i     (ex_valid),
    .ex_is_muldiv_i (ex_is_muldiv),
    .flush_i        (flush),
    .md_done_i      (md_done),
    .wb_ready_i     (wb_ready),
    .cache_hit_i    (cache_hit),
    .stall_o        (stall),
    .md_start_o     (md_start),
    .wb_valid_o     (wb_valid),
    .accept_o       (accept),
    .capture_o      (capture)
  );

  // Operands, control and rd are loaded only on accept and held until the next one.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    if (accept) begin
      a_d    = ex_rs1;
      b_d    = ex_rs2;
      ctrl_d = md_decode(ex_funct3);
      rd_d   = ex_rd;
    end
  end

  // Operand/control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
    end
  end

  // Result comes from the unit, or from the cache on a hit.
  always_comb begin
    data_d = data_q;
    if (capture)                data_d = md_R;
    else if (accept & cache_hit) data_d = hit_data;
  end

  // Result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic            retire;
  logic            cache_vld_q;
  logic [2:0]      cache_f3_q;
  logic [XLEN-1:0] cache_a_q;
  logic [XLEN-1:0] cache_b_q;
  logic [XLEN-1:0] cache_res_q;

  // Only ops that actually retire are cached, so flushed or drained ops never land here.
  assign retire    = wb_valid & wb_ready & ~flush;
  assign cache_hit = cache_vld_q & (cache_f3_q == ex_funct3) &
                     (cache_a_q == ex_rs1) & (cache_b_q == ex_rs2);
  assign hit_data  = cache_res_q;

  // Cache valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cache_vld_q <= 1'b0;
    else if (retire) cache_vld_q <= 1'b1;
  end

  // Cache payload; meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (retire) begin
      cache_f3_q  <= md_f3(ctrl_q);
      cache_a_q   <= a_q;
      cache_b_q   <= b_q;
      cache_res_q <= data_q;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  assign md_A      = a_q;
  assign md_B      = b_q;
  assign md_op_mul = ctrl_q.op_mul;
  assign md_op_div = ctrl_q.op_div;
  assign md_sel    = ctrl_q.sel;
  assign wb_rd     = rd_q;
  assign wb_data   = data_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue: behavioural muldiv unit with
// programmable latency, vector table of RV32M ops, scoreboard on writeback,
// and hand-written flush/drain/backpressure/reset/cache sequences.
module tb_muldiv_issue;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_muldiv, flush, wb_ready;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        stall, md_start, md_sel, md_done, wb_valid;
  logic [31:0] md_A, md_B, md_R, wb_data;
  logic [1:0]  md_op_mul, md_op_div;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_issue dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .flush(flush), .stall(stall), .md_start(md_start), .md_A(md_A), .md_B(md_B),
    .md_op_mul(md_op_mul), .md_op_div(md_op_div), .md_sel(md_sel), .md_R(md_R),
    .md_done(md_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural muldiv unit ----------------
  int   unit_lat = 0;
  int   cnt;
  logic busy;
  logic force_done = 1'b0;

  function automatic logic [31:0] unit_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic sel, input logic [1:0] om,
                                            input logic [1:0] od);
    logic [63:0] a64, b64, p;
    if (!sel) begin
      a64 = (om == 2'b01 || om == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      b64 = (om == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p   = a64 * b64;
      return (om == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return od[1] ? a : 32'hFFFF_FFFF;
    if (od[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return od[1] ? 32'd0 : a;
    if (od[0]) return od[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return od[1] ? a % b : a / b;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (md_start && unit_lat != 0) begin
      busy <= 1'b1;
      cnt  <= unit_lat;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) busy <= 1'b0;
    end
  end

  assign md_done = (md_start && unit_lat == 0) || (busy && cnt == 1) || force_done;
  assign md_R    = md_done ? unit_calc(md_A, md_B, md_sel, md_op_mul, md_op_div) : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_data_q[$];
  logic [4:0]  exp_rd_q[$];

  always @(negedge clk) begin
    if (reset && wb_valid && wb_ready) begin
      if (exp_data_q.size() == 0) begin
        chk("wb_unexpected_valid", 32'(wb_valid), 32'd0);
      end else begin
        chk("wb_data", wb_data, exp_data_q.pop_front());
        chk("wb_rd", 32'(wb_rd), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat);
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_rd = rd; unit_lat = lat;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_md_start"}, 32'(md_start), 32'd0);
    chk({tag, "_md_A"}, md_A, 32'd0);
    chk({tag, "_md_B"}, md_B, 32'd0);
    chk({tag, "_op_mul"}, 32'(md_op_mul), 32'd0);
    chk({tag, "_op_div"}, 32'(md_op_div), 32'd0);
    chk({tag, "_sel"}, 32'(md_sel), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  // Full op through the unit with wb_ready=1; returns at the handshake cycle.
  task automatic run_op(input int i);
    int         l;
    logic [2:0] f;
    l = tbl[i].lat;
    f = tbl[i].f3;
    step();
    wb_ready = 1'b1;
    drive_op(f, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, l);
    exp_data_q.push_back(tbl[i].exp);
    exp_rd_q.push_back(tbl[i].rd);
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    chk("start_accept", 32'(md_start), 32'd0);
    for (int k = 1; k <= l + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("md_start", 32'(md_start), 32'd1);
        chk("md_A", md_A, tbl[i].rs1);
        chk("md_B", md_B, tbl[i].rs2);
        chk("md_op_mul", 32'(md_op_mul), 32'(f[1:0]));
        chk("md_op_div", 32'(md_op_div), 32'({f[1], ~f[0]}));
        chk("md_sel", 32'(md_sel), 32'(f[2]));
      end else begin
        chk("md_start_pulse", 32'(md_start), 32'd0);
      end
      if (k < l + 2) begin
        chk("wb_valid_early", 32'(wb_valid), 32'd0);
        chk("stall_run", 32'(stall), 32'd1);
      end else begin
        chk("wb_valid_timing", 32'(wb_valid), 32'd1);
        chk("stall_retire", 32'(stall), 32'd0);
      end
    end
  endtask

  task automatic idle();
    step();
    ex_valid = 1'b0; ex_is_muldiv = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("wb_valid_idle", 32'(wb_valid), 32'd0);
  endtask

`ifdef MULDIV_RESULT_CACHE_EN
  task automatic cache_hit_op(input logic [4:0] rd);
    step();
    drive_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, 7);
    exp_data_q.push_back(32'hFFFF_FFFE);
    exp_rd_q.push_back(rd);
    @(negedge clk);
    chk("hit_stall_T", 32'(stall), 32'd1);
    @(negedge clk);
    chk("hit_no_start", 32'(md_start), 32'd0);
    chk("hit_wb_valid", 32'(wb_valid), 32'd1);
    chk("hit_stall_retire", 32'(stall), 32'd0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{F3_MUL,    32'd7,          32'd6,          5'd5,  5, 32'd42};
    tbl[1]  = '{F3_DIVU,   32'd100,        32'd0,          5'd9,  0, 32'hFFFF_FFFF};
    tbl[2]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000,  5'd10, 2, 32'h4000_0000};
    tbl[3]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 1, 32'hFFFF_FFFE};
    tbl[4]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd13, 3, 32'hFFFF_FFFF};
    tbl[5]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd14, 4, 32'hFFFF_FFFD};
    tbl[6]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd15, 1, 32'hFFFF_FFFF};
    tbl[7]  = '{F3_REMU,   32'd7,          32'd3,          5'd16, 0, 32'd1};
    tbl[8]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 2, 32'h8000_0000};
    tbl[9]  = '{F3_REM,    32'd5,          32'd0,          5'd18, 3, 32'd5};
    tbl[10] = '{F3_DIV,    32'd20,         32'd0,          5'd31, 1, 32'hFFFF_FFFF};

    reset = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    ex_funct3 = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0;
    @(negedge clk);
    chk_reset_outputs("rst");
    step();
    reset = 1'b1;

    // Table of ops, issued back-to-back at the earliest legal cycle.
    for (int i = 0; i < 11; i++) run_op(i);
    idle();

    // Writeback backpressure: HOLD for 3 cycles, retire on first wb_ready.
    step();
    wb_ready = 1'b0;
    drive_op(F3_MUL, 32'd3, 32'd5, 5'd7, 1);
    exp_data_q.push_back(32'd15);
    exp_rd_q.push_back(5'd7);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_wb_valid", 32'(wb_valid), 32'd1);
      chk("bp_wb_data", wb_data, 32'd15);
      chk("bp_stall", 32'(stall), 32'd1);
    end
    step();
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_stall_retire", 32'(stall), 32'd0);
    idle();

    // Flush a 10-cycle DIV at T+3; new MUL waits out the drain.
    step();
    drive_op(F3_DIV, 32'd50, 32'd5, 5'd4, 10);
    step();
    @(negedge clk);
    chk("dr_start", 32'(md_start), 32'd1);
    step();
    step();
    flush = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    chk("dr_flush_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0; ex_valid = 1'b1; ex_is_muldiv = 1'b0;
    @(negedge clk);
    chk("dr_nonmd_stall", 32'(stall), 32'd0);
    chk("dr_A_held", md_A, 32'd50);
    chk("dr_B_held", md_B, 32'd5);
    step();
    drive_op(F3_MUL, 32'd9, 32'd9, 5'd3, 2);
    exp_data_q.push_back(32'd81);
    exp_rd_q.push_back(5'd3);
    for (int k = 5; k <= 11; k++) begin
      @(negedge clk);
      chk("dr_stall", 32'(stall), 32'd1);
      chk("dr_wb_valid", 32'(wb_valid), 32'd0);
      chk("dr_no_start", 32'(md_start), 32'd0);
      if (k < 11) step();
    end
    step();
    @(negedge clk);
    chk("dr_accept_stall", 32'(stall), 32'd1);
    chk("dr_accept_start", 32'(md_start), 32'd0);
    @(negedge clk);
    chk("dr_mul_start", 32'(md_start), 32'd1);
    chk("dr_mul_A", md_A, 32'd9);
    repeat (2) begin
      @(negedge clk);
      chk("dr_mul_wait", 32'(wb_valid), 32'd0);
    end
    @(negedge clk);
    chk("dr_mul_wb_valid", 32'(wb_valid), 32'd1);
    chk("dr_mul_stall", 32'(stall), 32'd0);
    idle();

    // Flush together with md_done in RUN: result discarded, back to IDLE.
    step();
    drive_op(F3_MUL, 32'd2, 32'd2, 5'd6, 3);
    repeat (4) step();
    flush = 1'b1; ex_valid = 1'b0;
    step();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("fd_wb_valid", 32'(wb_valid), 32'd0);
      chk("fd_no_start", 32'(md_start), 32'd0);
    end
    run_op(7);
    idle();

    // Flush in HOLD drops wb_valid.
    step();
    wb_ready = 1'b0;
    drive_op(F3_MUL, 32'd11, 32'd3, 5'd2, 0);
    step();
    step();
    @(negedge clk);
    chk("fh_wb_valid", 32'(wb_valid), 32'd1);
    step();
    flush = 1'b1; ex_valid = 1'b0;
    step();
    flush = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("fh_dropped", 32'(wb_valid), 32'd0);

    // md_done while IDLE is ignored.
    step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    @(negedge clk);
    chk("sp_wb_valid", 32'(wb_valid), 32'd0);
    chk("sp_md_start", 32'(md_start), 32'd0);

`ifdef MULDIV_RESULT_CACHE_EN
    // Cache: repeat MULHU hits; a flushed differing op leaves the cache alone.
    run_op(3);
    cache_hit_op(5'd12);
    step();
    drive_op(F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd20, 4);
    step();
    step();
    flush = 1'b1; ex_valid = 1'b0;
    step();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cf_wb_valid", 32'(wb_valid), 32'd0);
    end
    cache_hit_op(5'd21);
    idle();
`endif

    // Asynchronous reset in RUN, then a clean accept.
    step();
    drive_op(F3_DIV, 32'd77, 32'd7, 5'd8, 10);
    step();
    step();
    reset = 1'b0;
    #1;
    chk_reset_outputs("arst");
    step();
    ex_valid = 1'b0; ex_is_muldiv = 1'b0;
    step();
    reset = 1'b1;
    run_op(3);
    idle();

    chk("sb_empty", 32'(exp_data_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
